// File: rtl/skew_bank_buf.sv
// skew_bank_buf
//   Multi-bank operand buffer for the systolic matrix-multiply datapath.
//   The buffer holds BANKS tiles of DIM x DIM signed elements. The host fills
//   one bank row by row while another bank streams out diagonally skewed,
//   either as the A operand (row skew) or as the B operand (column skew).
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en/wr_row/     write one row (element j = column j) into the current
//   wr_data           write bank
//   wr_commit         close the current write bank and advance the write pointer
//   wr_ready          current write bank accepts writes/commit
//   start, tr         request a stream of the current read bank; tr=0 row skew,
//                     tr=1 column skew
//   busy              a stream is in progress
//   done              pulse on the last beat of a stream
//   dout_valid, dout  registered skewed lanes; dout is zero when not valid
module skew_bank_buf #(
  parameter int BITS  = 8,
  parameter int DIM   = 8,
  parameter int BANKS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(DIM)-1:0]    wr_row,
  input  logic [DIM-1:0][BITS-1:0]  wr_data,
  input  logic                      wr_commit,
  output logic                      wr_ready,
  input  logic                      start,
  input  logic                      tr,
  output logic                      busy,
  output logic                      done,
  output logic                      dout_valid,
  output logic [DIM-1:0][BITS-1:0]  dout
);
  localparam int RW = $clog2(DIM);
  localparam int PW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TW = $clog2(2 * DIM);
  localparam logic [TW-1:0] LAST_BEAT = TW'(2 * DIM - 2);
  localparam logic [PW-1:0] LAST_BANK = PW'(BANKS - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, STREAMING} bank_state_e;

  bank_state_e               state_q [BANKS];
  bank_state_e               state_d [BANKS];
  // A row reads as zero until it has been written since the bank last emptied.
  logic [DIM-1:0]            mask_q  [BANKS];
  logic [DIM-1:0]            mask_d  [BANKS];
  logic [DIM-1:0][BITS-1:0]  mem_q   [BANKS][DIM];

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      valid_q, valid_d;
  logic                      tr_q, tr_d;
  logic [TW-1:0]             beat_q, beat_d;
  logic [DIM-1:0][BITS-1:0]  dout_q, dout_d;

  logic                      wr_ok;
  logic                      accept;
  logic [PW-1:0]             sel_bank;
  logic [TW-1:0]             sel_beat;
  logic                      sel_tr;
  int                        lane_k;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_BANK) ? '0 : p + PW'(1);
  endfunction

  assign wr_ok      = (state_q[wr_ptr_q] == EMPTY) || (state_q[wr_ptr_q] == FILLING);
  assign wr_ready   = wr_ok;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dout_valid = valid_q;
  assign dout       = dout_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    wr_ptr_d = wr_ptr_q;
    lane_k   = 0;

    // In the done cycle the read pointer already looks at the next bank, so a
    // start presented now can chain without a bubble.
    rd_ptr_d = done_q ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    accept   = start && (!busy_q || done_q) && (state_q[rd_ptr_d] == FULL);

    if (done_q) begin
      state_d[rd_ptr_q] = EMPTY;
      mask_d[rd_ptr_q]  = '0;
    end

    // The write bank is never the streaming or the freed bank, so these
    // updates cannot collide with the read side.
    if (wr_ok && wr_en) begin
      mask_d[wr_ptr_q][wr_row] = 1'b1;
      if (state_q[wr_ptr_q] == EMPTY) state_d[wr_ptr_q] = FILLING;
    end
    if (wr_ok && wr_commit) begin
      state_d[wr_ptr_q] = FULL;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end

    if (accept) state_d[rd_ptr_d] = STREAMING;

    sel_bank = accept ? rd_ptr_d : rd_ptr_q;
    sel_beat = accept ? '0 : beat_q + TW'(1);
    sel_tr   = accept ? tr : tr_q;

    busy_d  = accept || (busy_q && !done_q);
    valid_d = busy_d;
    beat_d  = busy_d ? sel_beat : '0;
    tr_d    = sel_tr;
    done_d  = busy_d && (sel_beat == LAST_BEAT);

    // Lane j carries diagonal element (j, t-j) of the tile, transposed in
    // column mode; terms off the tile stay zero.
    dout_d = '0;
    if (busy_d) begin
      for (int j = 0; j < DIM; j++) begin
        lane_k = int'(sel_beat) - j;
        if (lane_k >= 0 && lane_k < DIM) begin
          if (sel_tr) begin
            if (mask_q[sel_bank][lane_k[RW-1:0]])
              dout_d[RW'(j)] = mem_q[sel_bank][lane_k[RW-1:0]][RW'(j)];
          end else begin
            if (mask_q[sel_bank][RW'(j)])
              dout_d[RW'(j)] = mem_q[sel_bank][RW'(j)][lane_k[RW-1:0]];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        state_q[b] <= EMPTY;
        mask_q[b]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      tr_q     <= 1'b0;
      beat_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      tr_q     <= tr_d;
      beat_q   <= beat_d;
      dout_q   <= dout_d;
    end
  end

  // Tile storage carries no reset; the row mask hides anything stale.
  always_ff @(posedge clk) begin
    if (wr_ok && wr_en) mem_q[wr_ptr_q][wr_row] <= wr_data;
  end

endmodule

// File: tb/tb_skew_bank_buf.sv
module tb_skew_bank_buf;
  localparam int BITS  = 8;
  localparam int DIM   = 8;
  localparam int BANKS = 2;
  localparam int RW    = $clog2(DIM);
  localparam int LAST  = 2 * DIM - 2;
  localparam int S_EMPTY = 0, S_FILLING = 1, S_FULL = 2, S_STRM = 3;

  typedef logic [DIM-1:0][BITS-1:0] row_t;
  typedef struct {
    row_t d;
    bit   dn;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [RW-1:0] wr_row = '0;
  row_t          wr_data = '0;
  logic          wr_commit = 1'b0;
  logic          start = 1'b0;
  logic          tr = 1'b0;
  logic          wr_ready, busy, done, dout_valid;
  row_t          dout;

  skew_bank_buf #(.BITS(BITS), .DIM(DIM), .BANKS(BANKS)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_ready(wr_ready), .start(start), .tr(tr),
    .busy(busy), .done(done), .dout_valid(dout_valid), .dout(dout)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];

  // Reference model: tiles as plain integer matrices, bank status per bank,
  // and the beat index the DUT should be presenting (-1 when idle).
  int tile [BANKS][DIM][DIM];
  int bst [BANKS];
  int m_wp, m_rp, m_beat;

  int   run = 0;
  int   last_run = 0;
  row_t rd;

  task automatic chk1(input string nm, input logic a, input logic b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, b, $time);
    end
  endtask

  task automatic chkw(input string nm, input row_t a, input row_t b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, b, $time);
    end
  endtask

  task automatic chki(input string nm, input int a, input int b);
    total++;
    if (a != b) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, a, b, $time);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < BANKS; b++) begin
      bst[b] = S_EMPTY;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) tile[b][i][j] = 0;
    end
    m_wp = 0;
    m_rp = 0;
    m_beat = -1;
    exp_q.delete();
  endfunction

  function automatic void model_edge(input bit e, input int row, input row_t d,
                                     input bit c, input bit s, input bit t);
    bit    dn, rdy, acc;
    int    nrp, v, k;
    beat_t bb;
    dn  = (m_beat == LAST);
    rdy = (bst[m_wp] == S_EMPTY) || (bst[m_wp] == S_FILLING);
    nrp = dn ? (m_rp + 1) % BANKS : m_rp;
    acc = s && (m_beat < 0 || dn) && (bst[nrp] == S_FULL);
    if (acc) begin
      for (int tt = 0; tt <= LAST; tt++) begin
        for (int j = 0; j < DIM; j++) begin
          k = tt - j;
          v = 0;
          if (k >= 0 && k < DIM) v = t ? tile[nrp][k][j] : tile[nrp][j][k];
          bb.d[j] = v[BITS-1:0];
        end
        bb.dn = (tt == LAST);
        exp_q.push_back(bb);
      end
    end
    if (dn) begin
      bst[m_rp] = S_EMPTY;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) tile[m_rp][i][j] = 0;
    end
    m_rp = nrp;
    if (rdy && e) begin
      for (int j = 0; j < DIM; j++) tile[m_wp][row][j] = int'($signed(d[j]));
      if (bst[m_wp] == S_EMPTY) bst[m_wp] = S_FILLING;
    end
    if (rdy && c) begin
      bst[m_wp] = S_FULL;
      m_wp = (m_wp + 1) % BANKS;
    end
    if (acc) begin
      bst[nrp] = S_STRM;
      m_beat = 0;
    end else if (m_beat >= 0 && !dn) begin
      m_beat++;
    end else begin
      m_beat = -1;
    end
  endfunction

  // One clock: check flags for the current cycle, drive inputs for the next edge.
  task automatic cyc(input bit r, input bit e, input int row, input row_t d,
                     input bit c, input bit s, input bit t);
    @(negedge clk);
    chk1("wr_ready", wr_ready, (bst[m_wp] == S_EMPTY) || (bst[m_wp] == S_FILLING));
    chk1("busy", busy, m_beat >= 0);
    chk1("done", done, m_beat == LAST);
    rst_n     = !r;
    wr_en     = e;
    wr_row    = row[RW-1:0];
    wr_data   = d;
    wr_commit = c;
    start     = s;
    tr        = t;
    if (r) model_reset();
    else   model_edge(e, row, d, c, s, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill_random(input bit commit_last);
    row_t r;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) r[j] = BITS'($urandom);
      cyc(1'b0, 1'b1, i, r, commit_last && (i == DIM - 1), 1'b0, 1'b0);
    end
  endtask

  // Monitor: pops one expected beat for every valid DUT beat.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (dout_valid === 1'b1) begin
        run++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got dout=%h with no beat pending at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          chkw("dout", dout, e.d);
          chk1("done_beat", done, e.dn);
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        chkw("dout_idle", dout, '0);
        chk1("valid_idle", dout_valid, 1'b0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    model_reset();
    idle(2);

    // start with no FULL bank is ignored
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // row mode, M[i][j] = 8i+j; start coinciding with commit is ignored
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) rd[j] = BITS'(8 * i + j);
      cyc(1'b0, 1'b1, i, rd, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    idle(2 * DIM + 2);

    // column mode, negative values; last row written together with commit
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) rd[j] = BITS'(-(i + 1));
      cyc(1'b0, 1'b1, i, rd, i == DIM - 1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 1'b1);
    idle(2 * DIM + 2);

    // sparse: row 2 only, overwritten so the last write wins
    for (int j = 0; j < DIM; j++) rd[j] = BITS'($urandom);
    cyc(1'b0, 1'b1, 2, rd, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < DIM; j++) rd[j] = 8'h7F;
    cyc(1'b0, 1'b1, 2, rd, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    idle(2 * DIM + 2);

    // ping-pong: fill next bank during stream, blocked writes ignored,
    // second start in the done cycle
    fill_random(1'b1);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    fill_random(1'b1);
    for (int j = 0; j < DIM; j++) rd[j] = BITS'($urandom);
    cyc(1'b0, 1'b1, 0, rd, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3, rd, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++)
      cyc(1'b0, 1'b0, 0, '0, 1'b0, m_beat == LAST, 1'b1);
    idle(3);
    chki("pingpong_run", last_run, 2 * (2 * DIM - 1));

    // reset mid-stream at beat 5, then a start with nothing committed
    fill_random(1'b1);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && m_beat != 5; n++) idle(1);
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int j = 0; j < DIM; j++) rd[j] = BITS'($urandom);
      cyc($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, DIM - 1)), rd, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    // drain with a bounded wait
    for (int n = 0; n < 4 * DIM && (m_beat >= 0 || exp_q.size() != 0); n++) idle(1);
    idle(2);
    chki("drain_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skew_bank_buf.md
# skew_bank_buf

Parametrised, multi-bank operand buffer for the systolic matrix-multiply datapath. It generalises the fixed 8x8 A/B skew memories: it holds BANKS complete DIMxDIM signed tiles. Each tile streams out diagonally skewed in row mode (A operand) or column mode (B operand), selected per stream, so one tile can load while another streams. It sits between the host write interface and the systolic array's west/north edge inputs.

## Interface
- BITS, 8, signed element width
- DIM, 8, tile dimension and output lane count (power of two, >=2)
- BANKS, 2, tile banks in the ring (>=1)

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write row wr_row of the current write bank
- wr_row  in  $clog2(DIM)  row index
- wr_data  in  DIM x BITS  row elements; element j is column j
- wr_commit  in  1  mark current write bank FULL and advance write pointer
- wr_ready  out  1  current write bank is EMPTY/FILLING (accepts writes)
- start  in  1  request a stream of the current read bank
- tr  in  1  mode, sampled with accepted start: 0 = row skew (A), 1 = column skew (B)
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse on the last beat of a stream
- dout_valid  out  1  dout carries a stream beat
- dout  out  DIM x BITS  skewed lane outputs, registered

## Operation
- Per-bank state: EMPTY -> FILLING (first wr_en) -> FULL (wr_commit) -> STREAMING (accepted start) -> EMPTY (last beat).
- Write pointer and read pointer each wrap BANKS-1 -> 0.
- wr_en when wr_ready=0: ignored, no state change.
- wr_commit when wr_ready=0: ignored, no state change.
- wr_commit on an EMPTY bank: accepted; the tile is all zeros.
- Per-bank written-row mask, cleared when the bank enters EMPTY. Rows not written since then read as 0 when streamed; stale data is never emitted.
- wr_en and wr_commit in the same cycle: the row is written, then the bank is committed.
- Repeated writes to one row: the last write wins.
- Start acceptance: start=1 and read bank FULL and (busy=0 or done=1). Otherwise the start is ignored, with no queuing.
- Stream beat t = 0..2*DIM-2. Out-of-range terms output 0.
  - tr=0: lane j = M[j][t-j] if 0 <= t-j < DIM.
  - tr=1: lane j = M[t-j][j] if 0 <= t-j < DIM.
- At the last beat the bank returns to EMPTY, the read pointer advances, and the written-row mask clears.
- Elements pass through unmodified; no arithmetic.

## Timing
- Reset values:
  - All banks EMPTY, both pointers 0, masks clear.
  - wr_ready=1, busy=0, done=0, dout_valid=0, dout all 0.
- Reset mid-stream or mid-fill aborts everything; reset values are held from the next edge.
- Writes take effect at the clock edge. State flags are registered: a start in the same cycle as the commit of that bank is ignored; start is accepted from the following cycle.
- Latency: start accepted at edge c0; beats t=0..2*DIM-2 appear in cycles c1..c(2*DIM-1) with dout_valid=1 and busy=1.
- done=1 only in cycle c(2*DIM-1).
- dout=0 whenever dout_valid=0.
- Gapless chaining: a start accepted in the done cycle with the next bank FULL gives beat t=0 of the next bank in the following cycle; busy stays 1.
- Freed-bank visibility: a bank freed at the done edge shows wr_ready=1 in the next cycle, if it is the write bank.
- With BANKS=1, the write bank is blocked (wr_ready=0) from commit until its stream's done cycle completes.

## Test plan
- **Row mode, full tile.** DIM=8, BANKS=2. Write M[i][j]=8*i+j (rows 0..7), commit, start with tr=0 -> beat 0 dout = {0,0,...,0}; beat 3 lanes 0..3 = {3,10,17,24}, rest 0; beat 14 lane 7 = 63. done on beat 14 only.
- **Column mode, signed values.** Tile with M[i][j]=-(i+1). Start with tr=1 -> beat 1 lanes = {-2,-1,0,...,0}; beat 7 lane 0 = -8, lane 7 = -1.
- **Sparse write.** Write row 2 only, all elements 0x7F, commit, stream with tr=0 -> only lane 2 is nonzero, on beats 2..9 with value 127. Every other lane/beat is 0.
- **Ping-pong gapless.** Fill bank 0, fill bank 1 during bank 0's stream, start asserted in bank 0's done cycle -> 30 consecutive dout_valid cycles, busy never drops, two done pulses 15 cycles apart. wr_ready returns 1 the cycle after each done.
- **Illegal requests.**
  - start with no FULL bank -> busy stays 0.
  - wr_en while both banks FULL -> contents unchanged.
  - start in the same cycle as the commit -> ignored; accepted the next cycle.
- **Reset mid-stream.** rst_n=0 at beat 5 -> the next cycle shows dout=0, dout_valid=0, busy=0, wr_ready=1. A subsequent start is ignored until a new commit.
